// File: rtl/wash_seq.sv
// Wash-cycle sequencer: prices and validates a programme at start, then steps
// FILL/WASH/DRAIN/RINSE/SPIN on a seconds prescaler with pause, lid hold and abort.
module wash_seq #(
  parameter int TICK_DIV = 66000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [4:0]         weight,
  input  logic signed [11:0] bal_in,
  input  logic               lid_open,
  input  logic               pause,
  input  logic               abort,
  output logic [2:0]         phase,
  output logic [5:0]         phase_left,
  output logic [6:0]         total_left,
  output logic signed [11:0] bal_out,
  output logic               busy,
  output logic               done,
  output logic               valve,
  output logic               motor,
  output logic               pump,
  output logic               spin_hi
);

  // start, pause and abort are single-cycle request pulses sampled on the
  // rising edge; there is no ready/acknowledge, an ignored pulse is simply lost.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_HOLD  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  state_t          state, n_state;
  state_t          held, n_held;
  state_t          first_run, nx_run;
  logic [1:0]      mode_r, n_mode;
  logic [4:0]      weight_r, n_weight;
  logic [5:0]      n_pl;
  logic [6:0]      n_tl;
  logic signed [11:0] n_bal;
  logic            n_done;
  logic [CW-1:0]   cnt, n_cnt;
  logic            tick;
  logic [5:0]      price;
  logic [6:0]      prog_sum;
  logic            reject;

  function automatic logic [5:0] dur(input state_t ph, input logic [1:0] m,
                                     input logic [4:0] w);
    logic [5:0] d;
    d = 6'd0;
    case (ph)
      S_FILL:  d = (m == 2'd3) ? 6'd0 : 6'd3;
      S_WASH: begin
        case (m)
          2'd0:    d = 6'd10 + {1'b0, w};
          2'd1:    d = 6'd20 + {1'b0, w};
          2'd2:    d = 6'd30 + {1'b0, w};
          default: d = 6'd0;
        endcase
      end
      S_DRAIN: d = 6'd3;
      S_RINSE: begin
        case (m)
          2'd0:    d = 6'd5;
          2'd1:    d = 6'd10;
          2'd2:    d = 6'd15;
          default: d = 6'd0;
        endcase
      end
      S_SPIN: begin
        case (m)
          2'd0:    d = 6'd5;
          2'd1:    d = 6'd8;
          default: d = 6'd10;
        endcase
      end
      default: d = 6'd0;
    endcase
    return d;
  endfunction

  // First non-zero phase strictly after 'from'; S_IDLE when the programme is over.
  function automatic state_t next_run(input state_t from, input logic [1:0] m,
                                      input logic [4:0] w);
    state_t nx;
    nx = S_IDLE;
    for (int i = 5; i >= 1; i--) begin
      if (i > int'(from) && dur(state_t'(3'(i)), m, w) != 6'd0)
        nx = state_t'(3'(i));
    end
    return nx;
  endfunction

  always_comb begin
    price = 6'd0;
    case (mode)
      2'd0:    price = 6'd5 + {1'b0, weight};
      2'd1:    price = 6'd8 + {1'b0, weight};
      2'd2:    price = 6'd12 + {1'b0, weight};
      default: price = 6'd3;
    endcase
  end

  assign prog_sum = 7'(dur(S_FILL, mode, weight)) + 7'(dur(S_WASH, mode, weight))
                  + 7'(dur(S_DRAIN, mode, weight)) + 7'(dur(S_RINSE, mode, weight))
                  + 7'(dur(S_SPIN, mode, weight));
  assign reject    = (weight > 5'd20) || (bal_in < $signed({6'd0, price}));
  assign first_run = next_run(S_IDLE, mode, weight);
  assign nx_run    = next_run(state, mode_r, weight_r);
  assign tick      = (cnt == TICK_LAST);

  always_comb begin
    n_state  = state;
    n_held   = held;
    n_mode   = mode_r;
    n_weight = weight_r;
    n_pl     = phase_left;
    n_tl     = total_left;
    n_bal    = bal_out;
    n_done   = 1'b0;
    n_cnt    = cnt;
    case (state)
      S_IDLE, S_ERR: begin
        if (start) begin
          if (reject) begin
            n_state = S_ERR;
          end else begin
            n_state  = first_run;
            n_bal    = bal_in - $signed({6'd0, price});
            n_tl     = prog_sum;
            n_pl     = dur(first_run, mode, weight);
            n_mode   = mode;
            n_weight = weight;
            n_cnt    = '0;
          end
        end
      end
      S_HOLD: begin
        if (abort) begin
          n_state = S_IDLE;
          n_pl    = 6'd0;
          n_tl    = 7'd0;
          n_cnt   = '0;
        end else if (pause && !lid_open) begin
          n_state = held;
          n_cnt   = '0;
        end
      end
      default: begin
        if (tick) begin
          n_cnt = '0;
          n_tl  = total_left - 7'd1;
          if (phase_left <= 6'd1) begin
            if (nx_run == S_IDLE) begin
              n_state = S_IDLE;
              n_pl    = 6'd0;
              n_tl    = 7'd0;
              n_done  = 1'b1;
            end else begin
              n_state = nx_run;
              n_pl    = dur(nx_run, mode_r, weight_r);
            end
          end else begin
            n_pl = phase_left - 6'd1;
          end
        end else begin
          n_cnt = cnt + 1'b1;
        end
        // A tick that ends a phase still advances first, so HOLD remembers the new phase.
        if ((pause || lid_open) && n_state != S_IDLE) begin
          n_held  = n_state;
          n_state = S_HOLD;
          n_cnt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      held       <= S_IDLE;
      mode_r     <= 2'd0;
      weight_r   <= 5'd0;
      phase_left <= 6'd0;
      total_left <= 7'd0;
      bal_out    <= 12'sd0;
      done       <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      valve      <= 1'b0;
      motor      <= 1'b0;
      pump       <= 1'b0;
      spin_hi    <= 1'b0;
    end else begin
      state      <= n_state;
      held       <= n_held;
      mode_r     <= n_mode;
      weight_r   <= n_weight;
      phase_left <= n_pl;
      total_left <= n_tl;
      bal_out    <= n_bal;
      done       <= n_done;
      cnt        <= n_cnt;
      busy       <= (n_state != S_IDLE) && (n_state != S_ERR);
      valve      <= (n_state == S_FILL);
      motor      <= (n_state == S_WASH) || (n_state == S_RINSE) || (n_state == S_SPIN);
      pump       <= (n_state == S_DRAIN) || (n_state == S_SPIN);
      spin_hi    <= (n_state == S_SPIN);
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_wash_seq.sv
// Directed bench for wash_seq with TICK_DIV=4 (one second = 4 clocks).
module tb_wash_seq;

  logic clk;
  logic rst;
  logic start, lid_open, pause, abort;
  logic [1:0] mode;
  logic [4:0] weight;
  logic signed [11:0] bal_in;
  logic [2:0] phase;
  logic [5:0] phase_left;
  logic [6:0] total_left;
  logic signed [11:0] bal_out;
  logic busy, done, valve, motor, pump, spin_hi;

  int checks = 0;
  int errors = 0;

  wash_seq #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .weight(weight),
    .bal_in(bal_in), .lid_open(lid_open), .pause(pause), .abort(abort),
    .phase(phase), .phase_left(phase_left), .total_left(total_left),
    .bal_out(bal_out), .busy(busy), .done(done), .valve(valve),
    .motor(motor), .pump(pump), .spin_hi(spin_hi)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver tasks: inputs change and outputs are sampled on the falling edge
  task automatic do_start(input logic [1:0] m, input logic [4:0] w, input logic [11:0] b);
    @(negedge clk);
    mode = m; weight = w; bal_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    @(negedge clk); pause = 1'b1;
    @(negedge clk); pause = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic wait_phase(input logic [2:0] p, output int n);
    n = 0;
    while (phase !== p && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; lid_open = 0; pause = 0; abort = 0;
    mode = 0; weight = 0; bal_in = 0;
    repeat (2) @(negedge clk);
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rst_phase: got %0d want 0", phase); end
    checks++; if (phase_left !== 6'd0 || total_left !== 7'd0) begin errors++;
      $display("FAIL rst_counters: got %0d/%0d want 0/0", phase_left, total_left); end
    checks++; if (bal_out !== 12'sd0) begin errors++; $display("FAIL rst_bal: got %0d want 0", bal_out); end
    checks++; if ({busy, done, valve, motor, pump, spin_hi} !== 6'b0) begin errors++;
      $display("FAIL rst_flags: got %b want 000000", {busy, done, valve, motor, pump, spin_hi}); end
    rst = 1'b1;
  endtask

  task automatic test_normal();
    logic [2:0] exp_ph[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    int         lens[5]   = '{12, 48, 12, 20, 20};
    logic [3:0] acts[5]   = '{4'b1000, 4'b0100, 4'b0010, 4'b0100, 4'b0111};
    int n;
    int done_cnt;
    done_cnt = 0;
    do_start(2'd0, 5'd2, 12'd50);
    checks++; if (bal_out !== 12'sd43) begin errors++; $display("FAIL norm_bal: got %0d want 43", bal_out); end
    checks++; if (total_left !== 7'd28) begin errors++; $display("FAIL norm_total: got %0d want 28", total_left); end
    checks++; if (phase_left !== 6'd3) begin errors++; $display("FAIL norm_fill_left: got %0d want 3", phase_left); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL norm_busy: got %b want 1", busy); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (phase !== exp_ph[k]) begin errors++;
        $display("FAIL norm_phase%0d: got %0d want %0d", k, phase, exp_ph[k]); end
      checks++; if ({valve, motor, pump, spin_hi} !== acts[k]) begin errors++;
        $display("FAIL norm_act%0d: got %b want %b", k, {valve, motor, pump, spin_hi}, acts[k]); end
      if (k == 1) begin
        checks++; if (phase_left !== 6'd12 || total_left !== 7'd25) begin errors++;
          $display("FAIL norm_wash_entry: got %0d/%0d want 12/25", phase_left, total_left); end
      end
      n = 0;
      while (phase === exp_ph[k] && n < 200) begin
        if (done === 1'b1) done_cnt++;
        @(negedge clk);
        n++;
      end
      checks++; if (n != lens[k]) begin errors++;
        $display("FAIL norm_len%0d: got %0d cycles want %0d", k, n, lens[k]); end
    end
    checks++; if (phase !== 3'd0 || done !== 1'b1) begin errors++;
      $display("FAIL norm_end: got phase %0d done %b want 0 1", phase, done); end
    checks++; if (phase_left !== 6'd0 || total_left !== 7'd0 || busy !== 1'b0) begin errors++;
      $display("FAIL norm_end_cnt: got %0d/%0d busy %b want 0/0 0", phase_left, total_left, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || done_cnt != 0) begin errors++;
      $display("FAIL norm_done_once: got done %b early %0d want 0 0", done, done_cnt); end
  endtask

  task automatic test_spin_only();
    int n;
    logic valve_seen;
    valve_seen = 1'b0;
    do_start(2'd3, 5'd15, 12'd3);
    checks++; if (bal_out !== 12'sd0) begin errors++; $display("FAIL spin_bal: got %0d want 0", bal_out); end
    checks++; if (phase !== 3'd3 || phase_left !== 6'd3 || total_left !== 7'd13) begin errors++;
      $display("FAIL spin_entry: got %0d %0d/%0d want 3 3/13", phase, phase_left, total_left); end
    n = 0;
    while (phase === 3'd3 && n < 200) begin
      if (valve === 1'b1) valve_seen = 1'b1;
      @(negedge clk); n++;
    end
    checks++; if (n != 12) begin errors++; $display("FAIL spin_drain_len: got %0d want 12", n); end
    checks++; if (phase !== 3'd5 || phase_left !== 6'd10 || total_left !== 7'd10) begin errors++;
      $display("FAIL spin_entry2: got %0d %0d/%0d want 5 10/10", phase, phase_left, total_left); end
    n = 0;
    while (phase === 3'd5 && n < 200) begin
      if (valve === 1'b1) valve_seen = 1'b1;
      @(negedge clk); n++;
    end
    checks++; if (n != 40) begin errors++; $display("FAIL spin_len: got %0d want 40", n); end
    checks++; if (valve_seen !== 1'b0 || phase !== 3'd0) begin errors++;
      $display("FAIL spin_valve: got valve_seen %b phase %0d want 0 0", valve_seen, phase); end
  endtask

  task automatic test_reject();
    do_start(2'd2, 5'd20, 12'd31);
    checks++; if (phase !== 3'd7 || busy !== 1'b0) begin errors++;
      $display("FAIL rej_price: got phase %0d busy %b want 7 0", phase, busy); end
    checks++; if (bal_out !== 12'sd0) begin errors++; $display("FAIL rej_bal: got %0d want 0", bal_out); end
    pulse_pause();
    pulse_abort();
    @(negedge clk); lid_open = 1'b1;
    @(negedge clk); lid_open = 1'b0;
    checks++; if (phase !== 3'd7) begin errors++; $display("FAIL rej_ignore: got %0d want 7", phase); end
    do_start(2'd0, 5'd21, 12'd900);
    checks++; if (phase !== 3'd7 || bal_out !== 12'sd0) begin errors++;
      $display("FAIL rej_weight: got phase %0d bal %0d want 7 0", phase, bal_out); end
    do_start(2'd0, 5'd2, 12'd100);
    checks++; if (phase !== 3'd1 || bal_out !== 12'sd93 || total_left !== 7'd28) begin errors++;
      $display("FAIL rej_recover: got %0d bal %0d tl %0d want 1 93 28", phase, bal_out, total_left); end
  endtask

  task automatic test_lid();
    int n;
    wait_phase(3'd2, n);
    checks++; if (phase !== 3'd2 || phase_left !== 6'd12) begin errors++;
      $display("FAIL lid_wash: got %0d left %0d want 2 12", phase, phase_left); end
    n = 0;
    while (phase_left !== 6'd7 && n < 100) begin @(negedge clk); n++; end
    lid_open = 1'b1;
    @(negedge clk);
    checks++; if (phase !== 3'd6 || motor !== 1'b0) begin errors++;
      $display("FAIL lid_hold: got phase %0d motor %b want 6 0", phase, motor); end
    repeat (100) @(negedge clk);
    checks++; if (phase !== 3'd6 || phase_left !== 6'd7 || total_left !== 7'd20) begin errors++;
      $display("FAIL lid_frozen: got %0d %0d/%0d want 6 7/20", phase, phase_left, total_left); end
    lid_open = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (phase !== 3'd6) begin errors++; $display("FAIL lid_close: got %0d want 6", phase); end
    pulse_pause();
    checks++; if (phase !== 3'd2 || phase_left !== 6'd7 || motor !== 1'b1) begin errors++;
      $display("FAIL lid_resume: got %0d left %0d motor %b want 2 7 1", phase, phase_left, motor); end
    repeat (3) @(negedge clk);
    checks++; if (phase_left !== 6'd7) begin errors++; $display("FAIL lid_pre_tick: got %0d want 7", phase_left); end
    @(negedge clk);
    checks++; if (phase_left !== 6'd6) begin errors++; $display("FAIL lid_first_tick: got %0d want 6", phase_left); end
  endtask

  task automatic test_abort();
    int n;
    wait_phase(3'd4, n);
    pulse_pause();
    checks++; if (phase !== 3'd6) begin errors++; $display("FAIL abort_hold: got %0d want 6", phase); end
    pulse_abort();
    checks++; if (phase !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL abort_idle: got %0d done %b busy %b want 0 0 0", phase, done, busy); end
    checks++; if (bal_out !== 12'sd93) begin errors++; $display("FAIL abort_bal: got %0d want 93", bal_out); end
  endtask

  task automatic test_reset_mid_spin();
    int n;
    do_start(2'd3, 5'd0, 12'd10);
    checks++; if (phase !== 3'd3 || bal_out !== 12'sd7) begin errors++;
      $display("FAIL mrst_start: got %0d bal %0d want 3 7", phase, bal_out); end
    wait_phase(3'd5, n);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (phase !== 3'd0 || phase_left !== 6'd0 || total_left !== 7'd0 || bal_out !== 12'sd0) begin errors++;
      $display("FAIL mrst_vals: got %0d %0d/%0d bal %0d want 0 0/0 0", phase, phase_left, total_left, bal_out); end
    checks++; if ({busy, done, valve, motor, pump, spin_hi} !== 6'b0) begin errors++;
      $display("FAIL mrst_flags: got %b want 000000", {busy, done, valve, motor, pump, spin_hi}); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_precedence();
    do_start(2'd0, 5'd0, 12'd20);
    checks++; if (phase !== 3'd1 || bal_out !== 12'sd15 || total_left !== 7'd26) begin errors++;
      $display("FAIL prec_start: got %0d bal %0d tl %0d want 1 15 26", phase, bal_out, total_left); end
    repeat (11) @(negedge clk);
    checks++; if (phase !== 3'd1 || phase_left !== 6'd1) begin errors++;
      $display("FAIL prec_pre: got %0d left %0d want 1 1", phase, phase_left); end
    pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    checks++; if (phase !== 3'd6 || phase_left !== 6'd10 || total_left !== 7'd23 || valve !== 1'b0) begin errors++;
      $display("FAIL prec_hold: got %0d %0d/%0d valve %b want 6 10/23 0", phase, phase_left, total_left, valve); end
    pulse_pause();
    checks++; if (phase !== 3'd2 || phase_left !== 6'd10 || total_left !== 7'd23) begin errors++;
      $display("FAIL prec_resume: got %0d %0d/%0d want 2 10/23", phase, phase_left, total_left); end
    pulse_pause();
    pulse_abort();
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL prec_abort: got %0d want 0", phase); end
  endtask

  // scenario sequence and final report
  initial begin
    test_reset();
    test_normal();
    test_spin_only();
    test_reject();
    test_lid();
    test_abort();
    test_reset_mid_spin();
    test_precedence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_seq.md
# wash_seq

Wash-cycle sequencer that runs after the pre-wash input stage. On a start request it takes the programme (mode), load weight and balance, charges the programme price, then steps the machine through fill, wash, drain, rinse and spin. Phase durations are derived from mode and weight, and the block drives valve, motor and pump enables. It handles pause, lid interlock and abort, and reports phase and countdown values for the seven-segment scanners and status LEDs.

## Interface
- TICK_DIV, 66000000: clk cycles per countdown second (≥2); benches use 4.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle start request (isOn qualified by centre button); honoured only in IDLE.
- mode  in  2  0 quick, 1 standard, 2 heavy, 3 spin-only; sampled at start.
- weight  in  5  load in kg, legal 0..20; sampled at start.
- bal_in  in  12 signed  balance at start.
- lid_open  in  1  level, 1 = lid open.
- pause  in  1  one-cycle pulse; toggles RUN/HOLD.
- abort  in  1  one-cycle pulse; honoured only in HOLD.
- phase  out  3  0 IDLE, 1 FILL, 2 WASH, 3 DRAIN, 4 RINSE, 5 SPIN, 6 HOLD, 7 ERR.
- phase_left  out  6  seconds left in current phase.
- total_left  out  7  seconds left in whole programme.
- bal_out  out  12 signed  balance after charge.
- busy  out  1  1 in any state except IDLE/ERR.
- done  out  1  one-cycle pulse on programme completion.
- valve, motor, pump, spin_hi  out  1 each  actuator enables.

## Operation
- Durations (s): FILL 3 (0 for mode 3); WASH base {10,20,30,0}+weight (0 for mode 3); DRAIN 3; RINSE {5,10,15,0}; SPIN {5,8,10,10}.
- Price: {5,8,12,3} + weight, with the weight term 0 for mode 3. All inputs are sampled and stored at the start edge.
- IDLE + start:
  - If weight>20, or bal_in < price (signed compare), go to ERR. bal_out is unchanged.
  - Otherwise bal_out ← bal_in − price.
  - total_left ← sum of all five durations, max 3+50+3+15+10=81.
  - Enter the first phase with non-zero duration, in order FILL→WASH→DRAIN→RINSE→SPIN.
- On each tick in a run phase:
  - phase_left and total_left decrement.
  - When phase_left goes 1→0, load the next non-zero phase. Zero-duration phases are skipped in the same cycle.
  - After SPIN completes: done=1 for one cycle, then IDLE with phase_left=total_left=0.
- Actuators are 0 outside run phases:
  - valve = FILL.
  - motor = WASH|RINSE|SPIN.
  - pump = DRAIN|SPIN.
  - spin_hi = SPIN.
- HOLD:
  - Entered from any run phase on a pause pulse, or while lid_open=1. Lid opening forces HOLD within one cycle.
  - The interrupted phase and both counters are frozen. All actuators are 0.
  - Exit back to the stored phase on a pause pulse with lid_open=0. Closing the lid alone does not resume.
  - abort in HOLD returns to IDLE. There is no refund and no done pulse.
- ERR: stays until the next start, which is re-evaluated as from IDLE. lid_open, pause and abort are ignored there.
- start, pause and abort are ignored in states where they are not listed.
- pause and lid_open asserted in the same cycle from a run phase enter HOLD.

## Timing
- Reset (async, rst=0):
  - phase=IDLE; phase_left=total_left=0; bal_out=0.
  - busy, done and all actuators 0; prescaler cleared.
  - A reset mid-programme aborts immediately, with no refund.
- start→phase change, bal_out update and counter loading take 1 cycle (registered).
- Prescaler:
  - Counts only in run phases and is cleared on every phase entry and on HOLD exit.
  - Tick is asserted when the count reaches TICK_DIV−1, so the first tick of a phase occurs TICK_DIV cycles after entry.
- Phase transitions occur on the tick cycle edge. The new phase's outputs are valid the following cycle.
- done is asserted exactly one cycle, on the edge entering IDLE.
- All outputs are registered.

## Test plan
- TICK_DIV=4, mode 0, weight 2, bal_in 50, start:
  - bal_out=43, total_left=3+12+3+5+5=28.
  - Phases FILL/WASH/DRAIN/RINSE/SPIN last 12/48/12/20/20 cycles.
  - done pulses once, then IDLE.
- mode 3, weight 15, bal_in 3:
  - bal_out=0.
  - First phase DRAIN (3 s), then SPIN (10 s); valve never asserted.
- Rejection cases:
  - mode 2, weight 20, bal_in 31 → ERR, bal_out unchanged, busy=0.
  - weight 21, bal_in 900 → ERR.
  - A following legal start leaves ERR and runs.
- Lid interlock:
  - lid_open=1 mid-WASH with phase_left=7 → HOLD next cycle, motor=0, counters frozen for 100 cycles.
  - Closing the lid alone does not resume.
  - pause → WASH resumes with phase_left=7, and the first tick comes 4 cycles later.
- Abort and reset:
  - pause in RINSE, then abort → IDLE, done=0, bal_out keeps the charged value.
  - rst=0 mid-SPIN → all outputs immediately at reset values.
- Event precedence:
  - pause pulse in the same cycle as a tick ending FILL → HOLD with the stored phase WASH.
  - After resume, WASH starts with its full duration.
